// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage.
// Result-source kinds, load funct3 codes, FSM state type and small helpers.
package wb_pkg;

    // Result source selected for the retiring instruction
    localparam logic [1:0] KIND_NONE = 2'd0;
    localparam logic [1:0] KIND_ALU  = 2'd1;
    localparam logic [1:0] KIND_LOAD = 2'd2;
    localparam logic [1:0] KIND_PC4  = 2'd3;

    // Load size/sign encodings (RISC-V funct3)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Writeback FSM states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMMIT    = 2'd1,
        WAIT_LOAD = 2'd2
    } wb_state_t;

    // A commit writes the register file only for a real result and rd != x0
    function automatic logic writes_rf(
        input logic [1:0] kind,
        input logic [4:0] rd
    );
        return (kind != KIND_NONE) && (rd != 5'd0);
    endfunction

    // Non-load result selection; NONE produces zero
    function automatic logic [31:0] non_load_result(
        input logic [1:0]  kind,
        input logic [31:0] alu,
        input logic [31:0] pc4
    );
        logic [31:0] r;
        r = 32'd0;
        if (kind == KIND_ALU) begin
            r = alu;
        end else if (kind == KIND_PC4) begin
            r = pc4;
        end
        return r;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment and extension.
// Picks the addressed byte/halfword from the raw word and sign/zero extends.
module load_align
    import wb_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte lane chosen by the full low address
    always_comb begin
        byte_sel = raw[7:0];
        unique case (addr_lo)
            2'd0:    byte_sel = raw[7:0];
            2'd1:    byte_sel = raw[15:8];
            2'd2:    byte_sel = raw[23:16];
            default: byte_sel = raw[31:24];
        endcase
    end

    // Halfword lane ignores addr_lo[0]
    always_comb begin
        half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];
    end

    // Extension per load type; unknown funct3 behaves as LW
    always_comb begin
        data = raw;
        unique case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'd0, half_sel};
            F3_LW:   data = raw;
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: result select, load wait and registered RF write port.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module writeback_stage
    import wb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_kind,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_alu,
    input  logic [31:0] in_pc4,
    input  logic [2:0]  in_funct3,
    input  logic [1:0]  in_addr_lo,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic [4:0]  wr,
    output logic        write_enable,
    output logic [31:0] din,
    output logic        retire
`ifdef WB_INSTRET_EN
    ,
    output logic [31:0] instret
`endif
);

    wb_state_t   state_q, state_d;

    logic [4:0]  rd_q, rd_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [1:0]  kind_q, kind_d;

    logic [4:0]  wr_q, wr_d;
    logic        we_q, we_d;
    logic [31:0] din_q, din_d;
    logic        retire_q, retire_d;

    logic        accept;
    logic        rsp_take;
    logic        is_load;
    logic [31:0] load_data;

    load_align u_load_align (
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .raw     (mem_rsp_data),
        .data    (load_data)
    );

    // Ready depends on state only; a pending load blocks new work
    always_comb begin
        in_ready = (state_q != WAIT_LOAD);
    end

    assign accept   = in_valid & in_ready;
    assign is_load  = (in_kind == KIND_LOAD);
    assign rsp_take = (state_q == WAIT_LOAD) & mem_rsp_valid;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, COMMIT: begin
                if (accept) begin
                    state_d = is_load ? WAIT_LOAD : COMMIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_LOAD: begin
                if (mem_rsp_valid) begin
                    state_d = COMMIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture instruction fields on every accept
    always_comb begin
        rd_d      = rd_q;
        funct3_d  = funct3_q;
        addr_lo_d = addr_lo_q;
        kind_d    = kind_q;
        if (accept) begin
            rd_d      = in_rd;
            funct3_d  = in_funct3;
            addr_lo_d = in_addr_lo;
            kind_d    = in_kind;
        end
    end

    // Captured instruction fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q      <= 5'd0;
            funct3_q  <= 3'd0;
            addr_lo_q <= 2'd0;
            kind_q    <= KIND_NONE;
        end else begin
            rd_q      <= rd_d;
            funct3_q  <= funct3_d;
            addr_lo_q <= addr_lo_d;
            kind_q    <= kind_d;
        end
    end

    // Output next values: a commit follows a non-load accept or a load response
    always_comb begin
        wr_d     = wr_q;
        din_d    = din_q;
        we_d     = 1'b0;
        retire_d = 1'b0;
        unique case (1'b1)
            accept && !is_load: begin
                wr_d     = in_rd;
                din_d    = non_load_result(in_kind, in_alu, in_pc4);
                we_d     = writes_rf(in_kind, in_rd);
                retire_d = 1'b1;
            end
            rsp_take: begin
                wr_d     = rd_q;
                din_d    = load_data;
                we_d     = writes_rf(kind_q, rd_q);
                retire_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Registered register-file write port and retire pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q     <= 5'd0;
            we_q     <= 1'b0;
            din_q    <= 32'd0;
            retire_q <= 1'b0;
        end else begin
            wr_q     <= wr_d;
            we_q     <= we_d;
            din_q    <= din_d;
            retire_q <= retire_d;
        end
    end

    assign wr           = wr_q;
    assign write_enable = we_q;
    assign din          = din_q;
    assign retire       = retire_q;

`ifdef WB_INSTRET_EN
    logic [31:0] instret_q, instret_d;

    // Count each retire pulse; wraps naturally at 2^32
    always_comb begin
        instret_d = instret_q + {31'd0, retire_q};
    end

    // Retired-instruction counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_q <= 32'd0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`endif

endmodule
